laser_pulse_array: RTL and testbench

Parametrised multi-channel laser one-shot timer and successor to the fixed 16-cycle single-channel laser controller. Each channel turns its laser output on for a programmable number of clock cycles when its conditioned button pulse arrives, with selectable retrigger behaviour and a per-channel completion strobe. It sits directly behind the per-channel ButtonSync conditioners and drives the laser enable lines.

---
 rtl/laser_pkg.sv | 12 +
 rtl/laser_channel.sv | 95 +++++++++
 rtl/laser_pulse_array.sv | 33 +++
 tb/tb_laser_pulse_array.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared definitions for the laser pulse array: channel state encoding and its width.
package laser_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/laser_channel.sv
// One laser channel: one-shot FSM with counter, optional retrigger and (LASER_HOLDOFF_EN) a holdoff state.
module laser_channel
  import laser_pkg::*;
#(
  parameter int W      = 8,
  parameter int RETRIG = 0,
  parameter int HOLD   = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         B,
  input  logic [W-1:0] Len,
  output logic         XL,
  output logic         Done
);

  // state_q is the channel's observable FSM state for external checkers.
  state_e       state_q;
  logic [W-1:0] cnt_q;
  logic         xl_q;
  logic         done_q;
  logic         trig;
  logic         reload;

  assign trig   = B && (Len != '0);
  assign reload = (RETRIG != 0) && trig;

`ifdef LASER_HOLDOFF_EN
  // HOLD=0 is treated as a one-cycle holdoff.
  localparam int HW        = (HOLD >= 2) ? $clog2(HOLD) : 1;
  localparam int HOLD_LOAD = (HOLD >= 1) ? HOLD - 1 : 0;
  logic [HW-1:0] hold_q;
`else
  if (HOLD < 0) begin : g_bad_hold
    $error("laser_channel: HOLD must be non-negative");
  end
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      xl_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef LASER_HOLDOFF_EN
      hold_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_q <= ST_FIRE;
            cnt_q   <= Len - W'(1);
            xl_q    <= 1'b1;
          end
        end
        ST_FIRE: begin
          // A reload beats the terminal count, so no Done on that edge.
          if (reload) begin
            cnt_q <= Len - W'(1);
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
          end else begin
            xl_q   <= 1'b0;
            done_q <= 1'b1;
`ifdef LASER_HOLDOFF_EN
            state_q <= ST_HOLD;
            hold_q  <= HW'(HOLD_LOAD);
`else
            state_q <= ST_IDLE;
`endif
          end
        end
`ifdef LASER_HOLDOFF_EN
        ST_HOLD: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          xl_q    <= 1'b0;
        end
      endcase
    end
  end

  assign XL   = xl_q;
  assign Done = done_q;

endmodule

// File: rtl/laser_pulse_array.sv
// N independent laser one-shot channels sharing one pulse length; holdoff enabled by LASER_HOLDOFF_EN.
module laser_pulse_array
  import laser_pkg::*;
#(
  parameter int N      = 2,
  parameter int W      = 8,
  parameter int RETRIG = 0,
  parameter int HOLD   = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic [N-1:0] B,
  input  logic [W-1:0] Len,
  output logic [N-1:0] XL,
  output logic [N-1:0] Done
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    laser_channel #(
      .W      (W),
      .RETRIG (RETRIG),
      .HOLD   (HOLD)
    ) u_ch (
      .CLK  (CLK),
      .Reset(Reset),
      .B    (B[i]),
      .Len  (Len),
      .XL   (XL[i]),
      .Done (Done[i])
    );
  end

endmodule

// File: tb/tb_laser_pulse_array.sv
// Directed bench for laser_pulse_array: one RETRIG=0 and one RETRIG=1 instance driven in parallel.
module tb_laser_pulse_array;

  logic       clk;
  logic       rst_n;
  logic [1:0] b;
  logic [7:0] len;
  logic [1:0] xl0, dn0, xl1, dn1;

  int n_checks;
  int n_fail;

  // Per-window accumulators: dut0 ch0/ch1, dut1 ch0.
  int hi00, hi01, hi10;
  int dn00, dn01, dn10;
  int both_dn;
  logic [63:0] tr0, tr1, dtr0;

  laser_pulse_array #(.N(2), .W(8), .RETRIG(0), .HOLD(4)) dut0 (
    .CLK(clk), .Reset(rst_n), .B(b), .Len(len), .XL(xl0), .Done(dn0)
  );

  laser_pulse_array #(.N(2), .W(8), .RETRIG(1), .HOLD(4)) dut1 (
    .CLK(clk), .Reset(rst_n), .B(b), .Len(len), .XL(xl1), .Done(dn1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    hi00 = 0; hi01 = 0; hi10 = 0;
    dn00 = 0; dn01 = 0; dn10 = 0;
    both_dn = 0;
    tr0 = '0; tr1 = '0; dtr0 = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      hi00 += int'(xl0[0]);
      hi01 += int'(xl0[1]);
      hi10 += int'(xl1[0]);
      dn00 += int'(dn0[0]);
      dn01 += int'(dn0[1]);
      dn10 += int'(dn1[0]);
      both_dn += int'(dn0 == 2'b11);
      tr0  = {tr0[62:0], xl0[0]};
      tr1  = {tr1[62:0], xl1[0]};
      dtr0 = {dtr0[62:0], dn0[0]};
    end
  endtask

  task automatic press(input logic [1:0] mask);
    b = mask;
    run(1);
    b = 2'b00;
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    b        = 2'b00;
    len      = 8'd16;
    clear();

    #20;
    check("reset_xl0", 64'(xl0), 64'd0);
    check("reset_dn0", 64'(dn0), 64'd0);
    check("reset_xl1", 64'(xl1), 64'd0);
    check("reset_dn1", 64'(dn1), 64'd0);
    #30;
    rst_n = 1'b1;
    run(2);

    // Baseline: Len=16 single press on ch0
    clear();
    press(2'b01);
    run(20);
    check("base_hi",    64'(hi00), 64'd16);
    check("base_done",  64'(dn00), 64'd1);
    check("base_trace", tr0[20:0], 64'h1FFFE0);
    check("base_dtr",   dtr0[20:0], 64'h000010);
    check("base_ch1_xl", 64'(hi01), 64'd0);
    check("base_ch1_dn", 64'(dn01), 64'd0);
    run(6);

    // Second press 5 cycles after the first, Len=10
    len = 8'd10;
    clear();
    press(2'b01);
    run(4);
    press(2'b01);
    run(20);
    check("rt0_hi",    64'(hi00), 64'd10);
    check("rt0_done",  64'(dn00), 64'd1);
    check("rt0_trace", tr0[25:0], 64'h3FF0000);
    check("rt1_hi",    64'(hi10), 64'd15);
    check("rt1_done",  64'(dn10), 64'd1);
    check("rt1_trace", tr1[25:0], 64'h3FFF800);
    run(6);

    // Reload landing exactly on the terminal count, Len=3
    len = 8'd3;
    clear();
    press(2'b01);
    run(2);
    press(2'b01);
    run(8);
    check("edge0_hi",   64'(hi00), 64'd3);
    check("edge0_done", 64'(dn00), 64'd1);
    check("edge1_hi",   64'(hi10), 64'd6);
    check("edge1_done", 64'(dn10), 64'd1);
    run(6);

    // Len change mid-pulse and a Len=0 reload are both ignored
    len = 8'd6;
    clear();
    press(2'b01);
    len = 8'd0;
    run(2);
    press(2'b01);
    len = 8'd20;
    run(10);
    check("latch0_hi", 64'(hi00), 64'd6);
    check("latch1_hi", 64'(hi10), 64'd6);
    check("latch1_dn", 64'(dn10), 64'd1);
    run(6);

    // Reset 8 cycles into a Len=16 pulse; presses during reset are lost
    len = 8'd16;
    clear();
    press(2'b01);
    run(7);
    check("pre_rst_xl", 64'(xl0[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_xl0", 64'(xl0), 64'd0);
    check("mid_rst_dn0", 64'(dn0), 64'd0);
    check("mid_rst_xl1", 64'(xl1), 64'd0);
    b = 2'b01;
    run(2);
    b = 2'b00;
    rst_n = 1'b1;
    clear();
    run(20);
    check("post_rst_hi", 64'(hi00), 64'd0);
    check("post_rst_dn", 64'(dn00), 64'd0);

    // Len=0 press is ignored
    len = 8'd0;
    clear();
    press(2'b01);
    run(3);
    check("len0_hi0", 64'(hi00), 64'd0);
    check("len0_hi1", 64'(hi10), 64'd0);
    check("len0_dn0", 64'(dn00), 64'd0);

    // Both channels pressed on the same edge, Len=3
    len = 8'd3;
    clear();
    press(2'b11);
    run(6);
    check("both_hi0", 64'(hi00), 64'd3);
    check("both_hi1", 64'(hi01), 64'd3);
    check("both_dn0", 64'(dn00), 64'd1);
    check("both_dn1", 64'(dn01), 64'd1);
    check("both_same", 64'(both_dn), 64'd1);
    run(6);

    // Continuous press, Len=4
    len = 8'd4;
    clear();
    b = 2'b01;
    run(20);
    b = 2'b00;
`ifdef LASER_HOLDOFF_EN
    check("cont_trace", tr0[19:0], 64'hF0783);
    check("cont_done",  64'(dn00), 64'd2);
`else
    check("cont_trace", tr0[19:0], 64'hF7BDE);
    check("cont_done",  64'(dn00), 64'd4);
`endif
    run(12);

    // Maximum length 255
    len = 8'd255;
    clear();
    press(2'b01);
    run(260);
    check("max_hi",    64'(hi00), 64'd255);
    check("max_done",  64'(dn00), 64'd1);
    check("max_trace", tr0[6:0], 64'h40);
    check("max_dtr",   dtr0[6:0], 64'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
